// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: forwarding select codes and divider FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-stage register numbers/controls in and hazard controls out.
// The pipeline drives the master side, the hazard unit sits on the slave side.
interface hazard_unit_if #(
    parameter int REGADDR_W = 5,
    parameter int PERF_W    = 32
);
    import hazard_pkg::*;

    logic [REGADDR_W-1:0] rsD, rtD, rsE, rtE;
    logic [REGADDR_W-1:0] writeregE, writeregM, writeregW;
    logic                 regwriteE, regwriteM, regwriteW;
    logic                 memtoregE, memtoregM;
    logic                 branchD, jrD, divE;

    logic [1:0]           forwardAE, forwardBE;
    logic                 forwardAD, forwardBD;
    logic                 stallF, stallD, stallE;
    logic                 flushE, flushM;
    logic                 div_start, div_done;
    logic [PERF_W-1:0]    stall_cnt;
    div_state_e           div_state;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jrD, divE,
        input  forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, stallE, flushE, flushM,
               div_start, div_done, stall_cnt, div_state
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jrD, divE,
        output forwardAE, forwardBE, forwardAD, forwardBD,
               stallF, stallD, stallE, flushE, flushM,
               div_start, div_done, stall_cnt, div_state
    );

endinterface

// File: rtl/div_stall_fsm.sv
// Divider sequencer: launches a divide, holds EX for DIV_CYCLES busy cycles,
// then flags the result for one cycle while EX advances.
module div_stall_fsm
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       divE,
    output logic       div_stall,
    output logic       div_start,
    output logic       div_done,
    output div_state_e state
);

    logic [5:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (divE) begin
                        state <= DIV_BUSY;
                        cnt   <= 6'(DIV_CYCLES - 1);
                    end
                end
                DIV_BUSY: begin
                    if (cnt == 6'd0) state <= DIV_DONE;
                    else             cnt   <= cnt - 6'd1;
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    // The launch cycle already stalls: divE is seen in IDLE before the state moves.
    assign div_start = (state == DIV_IDLE) && divE;
    assign div_stall = div_start || (state == DIV_BUSY);
    assign div_done  = (state == DIV_DONE);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX/ID forwarding selects, load-use and branch stalls,
// divider hold sequencing. Define HAZ_PERF_CNT_EN to build the saturating stall counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input logic         clk,
    input logic         resetn,
    hazard_unit_if.slave hz
);

    logic [1:0] fwd_ae, fwd_be;
    logic       lwstall, brstall, br_dep_e, br_dep_m;
    logic       div_stall, div_start, div_done;
    logic       front_stall;

    always_comb begin
        fwd_ae = FWD_REG;
        if (hz.regwriteM && (hz.rsE != '0) && (hz.writeregM == hz.rsE))
            fwd_ae = FWD_MEM;
        else if (hz.regwriteW && (hz.rsE != '0) && (hz.writeregW == hz.rsE))
            fwd_ae = FWD_WB;
    end

    always_comb begin
        fwd_be = FWD_REG;
        if (hz.regwriteM && (hz.rtE != '0) && (hz.writeregM == hz.rtE))
            fwd_be = FWD_MEM;
        else if (hz.regwriteW && (hz.rtE != '0) && (hz.writeregW == hz.rtE))
            fwd_be = FWD_WB;
    end

    assign hz.forwardAE = fwd_ae;
    assign hz.forwardBE = fwd_be;
    assign hz.forwardAD = (hz.rsD != '0) && hz.regwriteM && (hz.writeregM == hz.rsD);
    assign hz.forwardBD = (hz.rtD != '0) && hz.regwriteM && (hz.writeregM == hz.rtD);

    // Branch compares in ID cannot take EX results or MEM load data, only MEM ALU out.
    assign lwstall  = hz.memtoregE && ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
    assign br_dep_e = hz.regwriteE && ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD));
    assign br_dep_m = hz.memtoregM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD));
    assign brstall  = (hz.branchD || hz.jrD) && (br_dep_e || br_dep_m);

    div_stall_fsm #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .divE      (hz.divE),
        .div_stall (div_stall),
        .div_start (div_start),
        .div_done  (div_done),
        .state     (hz.div_state)
    );

    // A running divide holds EX, so no bubble goes into ID-EX; the bubble moves to EX-MEM.
    assign front_stall  = lwstall || brstall || div_stall;
    assign hz.stallF    = front_stall;
    assign hz.stallD    = front_stall;
    assign hz.stallE    = div_stall;
    assign hz.flushM    = div_stall;
    assign hz.flushE    = (lwstall || brstall) && !div_stall;
    assign hz.div_start = div_start;
    assign hz.div_done  = div_done;

`ifdef HAZ_PERF_CNT_EN
    localparam int PERF_W = $bits(hz.stall_cnt);

    logic [PERF_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_cnt_q <= '0;
        else if (front_stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: driver pushes hand-computed expectations, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int W = 46;   // {cnt_chk, stall_cnt[31:0], ctl[12:0]}
`ifdef HAZ_PERF_CNT_EN
    localparam logic [31:0] EXP_PERF = 32'd8;
`else
    localparam logic [31:0] EXP_PERF = 32'd0;
`endif

    logic clk;
    logic resetn;

    hazard_unit_if #(.REGADDR_W(5), .PERF_W(32)) hz ();

    hazard_unit #(.DIV_CYCLES(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (hz)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           n_total = 0;
    int           n_bad   = 0;

    function automatic logic [12:0] mk(input logic [1:0] ae, input logic [1:0] be,
                                       input logic ad, input logic bd,
                                       input logic sf, input logic sd, input logic se,
                                       input logic fe, input logic fm,
                                       input logic ds, input logic dd);
        return {ae, be, ad, bd, sf, sd, se, fe, fm, ds, dd};
    endfunction

    // driver tasks
    task automatic clr();
        hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
        hz.writeregE = '0; hz.writeregM = '0; hz.writeregW = '0;
        hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
        hz.memtoregE = 1'b0; hz.memtoregM = 1'b0;
        hz.branchD = 1'b0; hz.jrD = 1'b0; hz.divE = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [12:0] ctl, input logic cc, input logic [31:0] cnt);
        exp_q.push_back({cc, cnt, ctl});
        id_q.push_back(id);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [12:0]  got;
            int           id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            got = {hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD,
                   hz.stallF, hz.stallD, hz.stallE, hz.flushE, hz.flushM,
                   hz.div_start, hz.div_done};
            n_total++;
            if (got !== e[12:0]) begin
                n_bad++;
                $display("FAIL ctl vec=%0d got=%b want=%b (AE BE AD BD sF sD sE fE fM ds dd)",
                         id, got, e[12:0]);
            end
            if (e[45]) begin
                n_total++;
                if (hz.stall_cnt !== e[44:13]) begin
                    n_bad++;
                    $display("FAIL stall_cnt vec=%0d got=%0d want=%0d", id, hz.stall_cnt, e[44:13]);
                end
            end
        end
    end

    initial begin
        logic [12:0] zero, lw, dstart, dbusy, ddone;
        zero   = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw     = mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        dstart = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 1, 1, 0);
        dbusy  = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 1, 0, 0);
        ddone  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        clr();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 push(0, zero, 1'b1, 32'd0);
        cyc(); resetn = 1'b1; push(1, zero, 1'b0, 32'd0);

        // forwarding priority and register 0
        cyc(); clr(); hz.rsE = 5'd5; hz.regwriteM = 1; hz.writeregM = 5'd5;
        hz.regwriteW = 1; hz.writeregW = 5'd5;
        push(10, mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0);
        cyc(); hz.regwriteM = 0;
        push(11, mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0);
        cyc(); hz.rsE = 5'd0;
        push(12, zero, 1'b0, 32'd0);
        cyc(); clr(); hz.rsE = 5'd9; hz.rtE = 5'd7; hz.regwriteM = 1; hz.writeregM = 5'd9;
        hz.regwriteW = 1; hz.writeregW = 5'd7;
        push(13, mk(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0);
        cyc(); clr(); hz.rtE = 5'd0; hz.regwriteM = 1; hz.writeregM = 5'd0;
        push(14, zero, 1'b0, 32'd0);

        // load-use
        cyc(); clr(); hz.memtoregE = 1; hz.rtE = 5'd8; hz.rsD = 5'd8;
        push(20, lw, 1'b0, 32'd0);
        cyc(); hz.memtoregE = 0;
        push(21, zero, 1'b0, 32'd0);

        // branch hazards
        cyc(); clr(); hz.branchD = 1; hz.rsD = 5'd3; hz.regwriteE = 1; hz.writeregE = 5'd3;
        push(30, lw, 1'b0, 32'd0);
        cyc(); hz.regwriteE = 0; hz.writeregE = 5'd0; hz.memtoregM = 1; hz.writeregM = 5'd3;
        push(31, lw, 1'b0, 32'd0);
        cyc(); hz.memtoregM = 0; hz.regwriteM = 1;
        push(32, mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0);
        cyc(); hz.rsD = 5'd0; hz.rtD = 5'd3; hz.branchD = 0; hz.jrD = 1;
        push(33, mk(2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 32'd0);

        // four-cycle divide
        cyc(); clr(); hz.divE = 1;
        push(40, dstart, 1'b0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc(); push(40 + i, dbusy, 1'b0, 32'd0);
        end
        cyc(); push(45, ddone, 1'b0, 32'd0);
        cyc(); hz.divE = 0; push(46, zero, 1'b0, 32'd0);

        // divide plus load-use, then reset mid-divide
        cyc(); clr(); hz.divE = 1; hz.memtoregE = 1; hz.rtE = 5'd8; hz.rsD = 5'd8;
        push(50, dstart, 1'b0, 32'd0);
        cyc(); hz.memtoregE = 0; hz.rtE = 5'd0; hz.rsD = 5'd0;
        push(51, dbusy, 1'b0, 32'd0);
        cyc(); resetn = 1'b0; hz.divE = 0;
        push(52, zero, 1'b1, 32'd0);
        cyc(); resetn = 1'b1; push(53, zero, 1'b0, 32'd0);
        cyc(); push(54, zero, 1'b0, 32'd0);

        // stall counter: three load-use cycles plus a divide
        for (int i = 0; i < 3; i++) begin
            cyc(); clr(); hz.memtoregE = 1; hz.rtE = 5'd8; hz.rtD = 5'd8;
            push(60 + i, lw, 1'b0, 32'd0);
        end
        cyc(); clr(); hz.divE = 1; push(63, dstart, 1'b0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc(); push(63 + i, dbusy, 1'b0, 32'd0);
        end
        cyc(); push(68, ddone, 1'b0, 32'd0);
        cyc(); hz.divE = 0; push(69, zero, 1'b1, EXP_PERF);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
